// File: rtl/paddle_cmd_mux.sv
// paddle_cmd_mux: builds the per-frame left/right paddle commands from the
// local keyboard keycodes and the remote player's packetised command stream.
// Outputs are latched only on a synchronized frame tick, so each paddle sees
// a stable command at its frame sample point.
//
// Remote byte handshake: a byte is consumed on a rising Clk edge where
// rx_valid and rx_ready are both high; rx_ready is registered and is low only
// in reset and during the single COMMIT cycle; rx_data is ignored otherwise.
module paddle_cmd_mux #(
    parameter logic [7:0] KEY_UP         = 8'h1A,
    parameter logic [7:0] KEY_DOWN       = 8'h16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] TIMEOUT_FRAMES = 8'd30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [31:0] kb_keycode,
    input  logic        local_is_left,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  keycode_left,
    output logic [7:0]  keycode_right,
    output logic        link_up,
    output logic        rx_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GOT_SYNC = 2'd1,
        S_GOT_CMD  = 2'd2,
        S_COMMIT   = 2'd3
    } rx_state_t;

    rx_state_t  r_state;
    logic [7:0] r_cmd_tmp;
    logic [7:0] r_remote_cmd;
    logic       r_rx_ready;
    logic       r_rx_err;
    logic [7:0] r_frame_cnt;
    logic       r_fc_meta;
    logic       r_fc_sync;
    logic       r_fc_prev;
    logic [7:0] r_key_left;
    logic [7:0] r_key_right;

    logic       w_up;
    logic       w_dn;
    logic [7:0] w_local_cmd;
    logic [7:0] w_remote_eff;
    logic       w_frame_tick;
    logic       w_xfer;
    logic       w_commit;
    logic       w_link_up;

    // Local command decode: scan all four keycode slots for up/down keys.
    always_comb begin
        w_up = 1'b0;
        w_dn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (kb_keycode[i*8 +: 8] == KEY_UP)   w_up = 1'b1;
            if (kb_keycode[i*8 +: 8] == KEY_DOWN) w_dn = 1'b1;
        end
        if (w_up && !w_dn)      w_local_cmd = 8'h02;
        else if (w_dn && !w_up) w_local_cmd = 8'h01;
        else                    w_local_cmd = 8'h00;
    end

    assign w_frame_tick = r_fc_sync & ~r_fc_prev;
    assign w_xfer       = rx_valid & r_rx_ready;
    assign w_commit     = (r_state == S_COMMIT);
    assign w_link_up    = (r_frame_cnt < TIMEOUT_FRAMES);
    assign w_remote_eff = w_link_up ? r_remote_cmd : 8'h00;

    // Bring frame_clk into the Clk domain and keep one delayed copy for edge detect.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fc_meta <= 1'b0;
            r_fc_sync <= 1'b0;
            r_fc_prev <= 1'b0;
        end else begin
            r_fc_meta <= frame_clk;
            r_fc_sync <= r_fc_meta;
            r_fc_prev <= r_fc_sync;
        end
    end

    // Packet receiver: SYNC, CMD, CHK, then one COMMIT cycle with ready low.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_cmd_tmp    <= 8'h00;
            r_remote_cmd <= 8'h00;
            r_rx_ready   <= 1'b0;
            r_rx_err     <= 1'b0;
        end else begin
            r_rx_err   <= 1'b0;
            r_rx_ready <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer && rx_data == SYNC_BYTE) r_state <= S_GOT_SYNC;
                end
                S_GOT_SYNC: begin
                    if (w_xfer) begin
                        r_cmd_tmp <= rx_data;
                        r_state   <= S_GOT_CMD;
                    end
                end
                S_GOT_CMD: begin
                    if (w_xfer) begin
                        if (rx_data == (SYNC_BYTE ^ r_cmd_tmp) && r_cmd_tmp <= 8'h02) begin
                            r_state    <= S_COMMIT;
                            r_rx_ready <= 1'b0;
                        end else begin
                            r_rx_err <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                S_COMMIT: begin
                    r_remote_cmd <= r_cmd_tmp;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Link watchdog: frames since the last good packet, saturating; a commit wins over a tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_frame_cnt <= TIMEOUT_FRAMES;
        end else if (w_commit) begin
            r_frame_cnt <= 8'h00;
        end else if (w_frame_tick && r_frame_cnt < TIMEOUT_FRAMES) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    // Per-frame output latch; remote_cmd is sampled before any same-cycle commit lands.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_key_left  <= 8'h00;
            r_key_right <= 8'h00;
        end else if (w_frame_tick) begin
            if (local_is_left) begin
                r_key_left  <= w_local_cmd;
                r_key_right <= w_remote_eff;
            end else begin
                r_key_left  <= w_remote_eff;
                r_key_right <= w_local_cmd;
            end
        end
    end

    assign rx_ready      = r_rx_ready;
    assign rx_err        = r_rx_err;
    assign link_up       = w_link_up;
    assign keycode_left  = r_key_left;
    assign keycode_right = r_key_right;

endmodule

// File: tb/tb_paddle_cmd_mux.sv
// Directed bench for paddle_cmd_mux: keyboard decode, packet receive,
// link timeout, commit/frame-tick collision and mid-packet reset.
module tb_paddle_cmd_mux;

    logic        Clk;
    logic        Reset;
    logic        frame_clk;
    logic [31:0] kb_keycode;
    logic        local_is_left;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  keycode_left;
    logic [7:0]  keycode_right;
    logic        link_up;
    logic        rx_err;

    int n_tests = 0;
    int n_fail  = 0;

    paddle_cmd_mux dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .kb_keycode    (kb_keycode),
        .local_is_left (local_is_left),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .keycode_left  (keycode_left),
        .keycode_right (keycode_right),
        .link_up       (link_up),
        .rx_err        (rx_err)
    );

    // Clock
    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One full frame_clk period; the output latch happens on the third edge after the rise.
    task automatic frame();
        frame_clk = 1'b1;
        cyc(5);
        frame_clk = 1'b0;
        cyc(5);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    // Present one byte and hold it until it is accepted (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 20) begin
            cyc(1);
            waited++;
        end
        if (!rx_ready) check("ready_timeout", 0, 1);
        cyc(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        cyc(2);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; kb_keycode = 32'h0; local_is_left = 1'b1;
        rx_data = 8'h00; rx_valid = 1'b0;
        cyc(3);
        check("rst_left", keycode_left, 8'h00);
        check("rst_right", keycode_right, 8'h00);
        check("rst_link", link_up, 1'b0);
        check("rst_ready", rx_ready, 1'b0);
        check("rst_err", rx_err, 1'b0);
        Reset = 1'b0;
        cyc(2);
        check("ready_after_rst", rx_ready, 1'b1);
        frames(3);
        check("idle_left", keycode_left, 8'h00);
        check("idle_right", keycode_right, 8'h00);
        check("idle_link", link_up, 1'b0);

        // Local keyboard decode
        kb_keycode = 32'h0000001A; frame();
        check("kb_up", keycode_left, 8'h02);
        kb_keycode = 32'h0016001A; frame();
        check("kb_both", keycode_left, 8'h00);
        kb_keycode = 32'h16000000; frame();
        check("kb_down_slot3", keycode_left, 8'h01);
        kb_keycode = 32'h0;
        // Key change without a tick must not reach the output
        kb_keycode = 32'h00001A00; cyc(8);
        check("kb_no_tick", keycode_left, 8'h01);
        kb_keycode = 32'h0; frame();

        // Good packet, rx_valid held through the commit cycle
        send_byte(8'hA5);
        send_byte(8'h01);
        rx_data = 8'hA4; rx_valid = 1'b1;
        cyc(1);
        check("commit_ready_low", rx_ready, 1'b0);
        cyc(1);
        check("commit_ready_back", rx_ready, 1'b1);
        rx_valid = 1'b0;
        check("pkt_link", link_up, 1'b1);
        check("pkt_before_tick", keycode_right, 8'h00);
        frame();
        check("pkt_right", keycode_right, 8'h01);
        check("pkt_left_local", keycode_left, 8'h00);
        local_is_left = 1'b0; kb_keycode = 32'h0000001A;
        cyc(4);
        check("swap_waits_tick", keycode_right, 8'h01);
        frame();
        check("swap_left", keycode_left, 8'h01);
        check("swap_right", keycode_right, 8'h02);
        local_is_left = 1'b1; kb_keycode = 32'h0;
        frame();

        // Bad checksum
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        check("badchk_err", rx_err, 1'b1);
        cyc(1);
        check("badchk_err_1cyc", rx_err, 1'b0);
        frame();
        check("badchk_no_upd", keycode_right, 8'h01);
        // Out-of-range command with a matching checksum
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hA6);
        check("badcmd_err", rx_err, 1'b1);
        cyc(1);
        check("badcmd_err_1cyc", rx_err, 1'b0);
        frame();
        check("badcmd_no_upd", keycode_right, 8'h01);
        // Garbage before the sync byte is skipped silently
        send_byte(8'h11);
        check("garbage_no_err0", rx_err, 1'b0);
        send_byte(8'h22);
        check("garbage_no_err1", rx_err, 1'b0);
        send_pkt(8'hA5, 8'h02, 8'hA7);
        check("after_garbage_err", rx_err, 1'b0);
        frame();
        check("after_garbage_right", keycode_right, 8'h02);

        // Link timeout
        send_pkt(8'hA5, 8'h01, 8'hA4);
        frames(29);
        check("to_29_link", link_up, 1'b1);
        check("to_29_right", keycode_right, 8'h01);
        frame();
        check("to_30_link", link_up, 1'b0);
        frame();
        check("to_31_forced", keycode_right, 8'h00);
        send_pkt(8'hA5, 8'h02, 8'hA7);
        check("relink_link", link_up, 1'b1);
        frame();
        check("relink_right", keycode_right, 8'h02);

        // Commit on the same edge as the frame tick
        send_byte(8'hA5);
        send_byte(8'h01);
        frame_clk = 1'b1;
        cyc(1);
        rx_data = 8'hA4; rx_valid = 1'b1;
        cyc(1);
        rx_valid = 1'b0;
        cyc(1);
        check("coll_old_value", keycode_right, 8'h02);
        check("coll_cnt_clear", dut.r_frame_cnt, 8'h00);
        check("coll_link", link_up, 1'b1);
        cyc(2);
        frame_clk = 1'b0;
        cyc(5);
        frame();
        check("coll_next_tick", keycode_right, 8'h01);

        // Reset in the middle of a packet
        kb_keycode = 32'h0000001A; frame();
        send_byte(8'hA5);
        Reset = 1'b1;
        #3;
        check("midrst_left", keycode_left, 8'h00);
        check("midrst_right", keycode_right, 8'h00);
        cyc(2);
        Reset = 1'b0;
        kb_keycode = 32'h0;
        cyc(2);
        send_byte(8'h01);
        send_byte(8'hA4);
        cyc(2);
        check("midrst_no_commit_link", link_up, 1'b0);
        check("midrst_no_err", rx_err, 1'b0);
        frame();
        check("midrst_right_after", keycode_right, 8'h00);
        check("midrst_left_after", keycode_left, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
